awgn_stat_monitor: RTL and testbench
====================================

# awgn_stat_monitor

Windowed statistics engine at the consuming end of the Gaussian noise generator's output interface. It accepts sample pairs on the generator's two 16-bit AWGN outputs, qualified by its valid strobe. Over a window of 2^LOG2_N accepted pairs it accumulates sum, sum of squares, cross-product, min/max and an outlier count. It serves as the on-chip self-check and characterisation block for the noise source.

## Interface
Parameters:
- LOG2_N, default 10: window length, 2^LOG2_N accepted pairs (2^(LOG2_N+1) samples).
- OUTLIER_TH, default 16'd8192: magnitude threshold, unsigned, same Q-format as samples (8192 = 4.0).

Ports:
- iClk  in  1  clock, all logic on rising edge.
- iRst  in  1  reset, asynchronous, active-high.
- iStart  in  1  single-cycle request to open a window.
- iValid  in  1  sample pair valid (connects to generator oValid).
- iAwgn1  in  16  signed two's-complement sample, 11 fractional bits.
- iAwgn2  in  16  second sample, same format.
- oBusy  out  1  window open or pipeline draining.
- oDone  out  1  one-cycle pulse; result outputs updated.
- oSum  out  LOG2_N+17  signed, sum of all samples, both channels.
- oSumSq  out  LOG2_N+32  unsigned, sum of squares, both channels.
- oCorr  out  LOG2_N+32  signed, sum of iAwgn1*iAwgn2.
- oMax  out  16  signed, largest sample.
- oMin  out  16  signed, smallest sample.
- oOutliers  out  LOG2_N+2  count of samples with |x| > OUTLIER_TH.

## Operation
- FSM: IDLE, RUN, DRAIN.
  - IDLE: iValid ignored. On iStart, clear accumulators and pair counter, then go to RUN.
  - RUN: each cycle with iValid=1 accepts one pair. When the pair with counter = 2^LOG2_N-1 is accepted, go to DRAIN.
  - DRAIN: wait for the pipeline to empty. Load result registers, pulse oDone, return to IDLE.
- iStart while in RUN or DRAIN is ignored. iStart and iValid in the same IDLE cycle: that sample is not counted.
- Stage 1 registers on accept:
  - both samples;
  - both squares (31-bit unsigned; (-32768)^2 = 2^30);
  - cross product (32-bit signed);
  - |x| for each sample (17-bit, so |-32768| = 32768 exact);
  - a stage valid bit.
- Stage 2, on stage valid:
  - accumulate sum, squares and product at full width; no saturation or wrap is possible at the declared widths;
  - update running min/max (internal init 16'sh7FFF / 16'sh8000);
  - increment outlier count by 0, 1 or 2; the compare is strict >.
- iValid in DRAIN cannot occur in a legal window and is ignored.
- Result outputs hold the previous window's values until the next oDone. Outputs never show partial accumulations.
- Reset: all outputs 0, FSM IDLE, accumulators and pipeline cleared. Reset mid-window aborts the window with no oDone.

## Timing
- Pair accepted at edge E: stage 1 loads at E, accumulators at E+1.
- Results and oDone=1 are driven after edge E+2, where E is the last accepted pair. Latency from last valid to oDone is 2 cycles.
- oDone is high exactly one cycle.
- oBusy rises after the edge that samples iStart. It falls in the same cycle oDone rises.
- Gaps in iValid are allowed. The window closes only on the count, never on a timeout.
- Back-to-back windows: iStart is accepted in the cycle oDone is high (FSM already IDLE).

## Test plan
1. LOG2_N=2; iAwgn1=2048, iAwgn2=-2048 for 4 consecutive valids -> oSum=0, oSumSq=33554432, oCorr=-16777216, oMax=2048, oMin=-2048, oOutliers=0. oDone 2 cycles after the last valid.
2. Same data with iValid high every other cycle -> identical results; oBusy stays high through the gaps; oDone 2 cycles after the 4th valid.
3. LOG2_N=2; iAwgn1=-32768, iAwgn2=32767 x4 -> oSum=-4, oSumSq=8589672452, oCorr=-4294836224, oMin=-32768, oMax=32767, oOutliers=8.
4. Threshold boundary, one window of 4 pairs:
   - pairs (8192,-8192) x2 and (8193,-8193) x2 -> oOutliers=4;
   - repeat with all pairs (8192,-8192) -> oOutliers=0.
5. Handshake edges:
   - iValid pulses in IDLE -> no effect;
   - iStart+iValid in the same cycle -> that sample excluded;
   - second iStart mid-RUN -> ignored; window still ends after 4 pairs.
6. iRst asserted after 2 accepted pairs -> all outputs 0 immediately, oBusy=0, no oDone. A fresh window run afterwards matches scenario 1 exactly.

Source files
------------

// File: rtl/awgn_stat_monitor.sv
// awgn_stat_monitor: windowed sum, energy, cross-correlation, extrema and outlier count over AWGN sample pairs
module awgn_stat_monitor #(
   parameter int          LOG2_N     = 10,
   parameter logic [15:0] OUTLIER_TH = 16'd8192
) (
   input  logic                     iClk,
   input  logic                     iRst,
   input  logic                     iStart,
   input  logic                     iValid,
   input  logic signed [15:0]       iAwgn1,
   input  logic signed [15:0]       iAwgn2,
   output logic                     oBusy,
   output logic                     oDone,
   output logic signed [LOG2_N+16:0] oSum,
   output logic [LOG2_N+31:0]       oSumSq,
   output logic signed [LOG2_N+31:0] oCorr,
   output logic signed [15:0]       oMax,
   output logic signed [15:0]       oMin,
   output logic [LOG2_N+1:0]        oOutliers
);
   localparam logic [16:0] TH17 = {1'b0, OUTLIER_TH};
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} stateT;
   stateT state, stateNext;
   logic [LOG2_N-1:0] pairCnt;
   logic open, accept, finish;
   logic signed [31:0] xA, xB, prod;
   logic [30:0] sqA, sqB;
   logic [16:0] absA, absB;
   logic s1Vld;
   logic signed [15:0] s1A, s1B;
   logic [30:0] s1SqA, s1SqB;
   logic signed [31:0] s1Prod;
   logic [16:0] s1AbsA, s1AbsB;
   logic [16:0] pairSum;
   logic [31:0] pairSq;
   logic [1:0] pairOut;
   logic signed [15:0] pairHi, pairLo, newMax, newMin;
   logic signed [LOG2_N+16:0] accSum;
   logic [LOG2_N+31:0] accSq;
   logic signed [LOG2_N+31:0] accCorr;
   logic signed [15:0] accMax, accMin;
   logic [LOG2_N+1:0] accOut;
   assign open   = state == IDLE && iStart;
   assign accept = state == RUN && iValid;
   assign finish = state == DRAIN && !s1Vld;
   assign oBusy  = state != IDLE;
   always_ff @(posedge iClk or posedge iRst)
      if (iRst) state <= IDLE;
      else state <= stateNext;
   always_comb begin
      stateNext = state;
      stateNext = open ? RUN : (accept && &pairCnt) ? DRAIN : finish ? IDLE : state;
   end
   // low 31 bits of the sign-extended sample square exactly, since x^2 <= 2^30
   assign xA   = {{16{iAwgn1[15]}}, iAwgn1};
   assign xB   = {{16{iAwgn2[15]}}, iAwgn2};
   assign prod = xA * xB;
   assign sqA  = xA[30:0] * xA[30:0];
   assign sqB  = xB[30:0] * xB[30:0];
   assign absA = xA[31] ? -xA[16:0] : xA[16:0];
   assign absB = xB[31] ? -xB[16:0] : xB[16:0];
   always_ff @(posedge iClk or posedge iRst)
      if (iRst) begin
         s1Vld  <= 1'b0;
         s1A    <= '0;
         s1B    <= '0;
         s1SqA  <= '0;
         s1SqB  <= '0;
         s1Prod <= '0;
         s1AbsA <= '0;
         s1AbsB <= '0;
      end else begin
         s1Vld <= accept;
         if (accept) begin
            s1A    <= iAwgn1;
            s1B    <= iAwgn2;
            s1SqA  <= sqA;
            s1SqB  <= sqB;
            s1Prod <= prod;
            s1AbsA <= absA;
            s1AbsB <= absB;
         end
      end
   assign pairSum = {s1A[15], s1A} + {s1B[15], s1B};
   assign pairSq  = {1'b0, s1SqA} + {1'b0, s1SqB};
   assign pairOut = {1'b0, s1AbsA > TH17} + {1'b0, s1AbsB > TH17};
   assign pairHi  = s1A > s1B ? s1A : s1B;
   assign pairLo  = s1A < s1B ? s1A : s1B;
   assign newMax  = pairHi > accMax ? pairHi : accMax;
   assign newMin  = pairLo < accMin ? pairLo : accMin;
   always_ff @(posedge iClk or posedge iRst)
      if (iRst) begin
         pairCnt <= '0;
         accSum  <= '0;
         accSq   <= '0;
         accCorr <= '0;
         accMax  <= '0;
         accMin  <= '0;
         accOut  <= '0;
      end else if (open) begin
         pairCnt <= '0;
         accSum  <= '0;
         accSq   <= '0;
         accCorr <= '0;
         accMax  <= 16'sh8000;
         accMin  <= 16'sh7FFF;
         accOut  <= '0;
      end else begin
         if (accept) pairCnt <= pairCnt + LOG2_N'(1);
         if (s1Vld) begin
            accSum  <= accSum + {{LOG2_N{pairSum[16]}}, pairSum};
            accSq   <= accSq + {{LOG2_N{1'b0}}, pairSq};
            accCorr <= accCorr + {{LOG2_N{s1Prod[31]}}, s1Prod};
            accMax  <= newMax;
            accMin  <= newMin;
            accOut  <= accOut + {{LOG2_N{1'b0}}, pairOut};
         end
      end
   always_ff @(posedge iClk or posedge iRst)
      if (iRst) begin
         oDone     <= 1'b0;
         oSum      <= '0;
         oSumSq    <= '0;
         oCorr     <= '0;
         oMax      <= '0;
         oMin      <= '0;
         oOutliers <= '0;
      end else begin
         oDone <= finish;
         if (finish) begin
            oSum      <= accSum;
            oSumSq    <= accSq;
            oCorr     <= accCorr;
            oMax      <= accMax;
            oMin      <= accMin;
            oOutliers <= accOut;
         end
      end
endmodule

// File: tb/tb_awgn_stat_monitor.sv
// tb_awgn_stat_monitor: table vectors, handshake/reset sequences and random windows against a loop-based model
module tb_awgn_stat_monitor;
   logic iClk, iRst, iStart, iValid;
   logic signed [15:0] iAwgn1, iAwgn2;
   logic oBusy, oDone;
   logic signed [18:0] oSum;
   logic [33:0] oSumSq;
   logic signed [33:0] oCorr;
   logic signed [15:0] oMax, oMin;
   logic [3:0] oOutliers;
   int checks = 0, failures = 0;

   awgn_stat_monitor #(.LOG2_N(2), .OUTLIER_TH(16'd8192)) dut (
      .iClk(iClk), .iRst(iRst), .iStart(iStart), .iValid(iValid),
      .iAwgn1(iAwgn1), .iAwgn2(iAwgn2), .oBusy(oBusy), .oDone(oDone),
      .oSum(oSum), .oSumSq(oSumSq), .oCorr(oCorr), .oMax(oMax), .oMin(oMin),
      .oOutliers(oOutliers)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   typedef logic [3:0][15:0] quadT;
   typedef struct {
      quadT a, b;
      int gap;
      longint eSum, eSq, eCorr;
      int eMax, eMin, eOut;
   } vecT;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step(input logic s, input logic v, input logic [15:0] a, input logic [15:0] b);
      iStart = s;
      iValid = v;
      iAwgn1 = a;
      iAwgn2 = b;
      @(negedge iClk);
   endtask

   task automatic chkRes(input string tag, input longint eSum, input longint eSq, input longint eCorr,
                         input int eMax, input int eMin, input int eOut);
      chk({tag, " sum"}, longint'(oSum), eSum);
      chk({tag, " sumsq"}, longint'(oSumSq), eSq);
      chk({tag, " corr"}, longint'(oCorr), eCorr);
      chk({tag, " max"}, longint'(oMax), longint'(eMax));
      chk({tag, " min"}, longint'(oMin), longint'(eMin));
      chk({tag, " outliers"}, longint'(oOutliers), longint'(eOut));
   endtask

   // startValid: drive iValid with iStart; midStart: re-pulse iStart after the second pair
   task automatic runWindow(input string tag, input quadT a, input quadT b, input int gap,
                            input logic startValid, input logic midStart,
                            input longint eSum, input longint eSq, input longint eCorr,
                            input int eMax, input int eMin, input int eOut);
      step(1'b1, startValid, 16'd30000, 16'd30000);
      chk({tag, " busy after start"}, longint'(oBusy), 1);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, a[i], b[i]);
         if (i < 3) begin
            for (int g = 0; g < gap; g++) begin
               step(1'b0, 1'b0, 16'd0, 16'd0);
               chk({tag, " busy in gap"}, longint'(oBusy), 1);
            end
            if (midStart && i == 1) begin
               step(1'b1, 1'b0, 16'd0, 16'd0);
               chk({tag, " busy after mid start"}, longint'(oBusy), 1);
            end
         end
      end
      chk({tag, " done at +1"}, longint'(oDone), 0);
      step(1'b0, 1'b0, 16'd0, 16'd0);
      chk({tag, " done at +2 edge-1"}, longint'(oDone), 0);
      chk({tag, " busy draining"}, longint'(oBusy), 1);
      step(1'b0, 1'b0, 16'd0, 16'd0);
      chk({tag, " done"}, longint'(oDone), 1);
      chk({tag, " busy with done"}, longint'(oBusy), 0);
      chkRes(tag, eSum, eSq, eCorr, eMax, eMin, eOut);
   endtask

   task automatic model(input quadT a, input quadT b, output longint s, output longint q,
                        output longint c, output int mx, output int mn, output int o);
      s = 0; q = 0; c = 0; mx = -32768; mn = 32767; o = 0;
      for (int i = 0; i < 4; i++) begin
         int x, y;
         x = $signed(a[i]);
         y = $signed(b[i]);
         s += x + y;
         q += longint'(x * x) + longint'(y * y);
         c += longint'(x * y);
         mx = (x > mx) ? x : mx;
         mx = (y > mx) ? y : mx;
         mn = (x < mn) ? x : mn;
         mn = (y < mn) ? y : mn;
         o += ((x < 0 ? -x : x) > 8192) ? 1 : 0;
         o += ((y < 0 ? -y : y) > 8192) ? 1 : 0;
      end
   endtask

   function automatic logic [15:0] rnd();
      int m, v;
      m = $urandom_range(0, 3);
      case (m)
         0: v = int'($urandom_range(0, 65535)) - 32768;
         1: v = int'($urandom_range(8190, 8194)) * ($urandom_range(0, 1) ? 1 : -1);
         2: v = $urandom_range(0, 1) ? 32767 : -32768;
         default: v = int'($urandom_range(0, 4095)) - 2048;
      endcase
      return v[15:0];
   endfunction

   vecT vec[5];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      vec[0].a = {4{16'd2048}};        vec[0].b = {4{-16'sd2048}}; vec[0].gap = 0;
      vec[0].eSum = 0; vec[0].eSq = 33554432; vec[0].eCorr = -16777216;
      vec[0].eMax = 2048; vec[0].eMin = -2048; vec[0].eOut = 0;
      vec[1] = vec[0]; vec[1].gap = 1;
      vec[2].a = {4{-16'sd32768}};     vec[2].b = {4{16'sd32767}}; vec[2].gap = 0;
      vec[2].eSum = -4; vec[2].eSq = 64'd8589672452; vec[2].eCorr = -64'sd4294836224;
      vec[2].eMax = 32767; vec[2].eMin = -32768; vec[2].eOut = 8;
      vec[3].a = {16'd8193, 16'd8193, 16'd8192, 16'd8192};
      vec[3].b = {-16'sd8193, -16'sd8193, -16'sd8192, -16'sd8192}; vec[3].gap = 2;
      vec[3].eSum = 0; vec[3].eSq = 536936452; vec[3].eCorr = -268468226;
      vec[3].eMax = 8193; vec[3].eMin = -8193; vec[3].eOut = 4;
      vec[4].a = {4{16'd8192}};        vec[4].b = {4{-16'sd8192}}; vec[4].gap = 0;
      vec[4].eSum = 0; vec[4].eSq = 536870912; vec[4].eCorr = -268435456;
      vec[4].eMax = 8192; vec[4].eMin = -8192; vec[4].eOut = 0;

      iRst = 1'b1; iStart = 1'b0; iValid = 1'b0; iAwgn1 = '0; iAwgn2 = '0;
      repeat (2) @(negedge iClk);
      chk("reset busy", longint'(oBusy), 0);
      chk("reset done", longint'(oDone), 0);
      chkRes("reset", 0, 0, 0, 0, 0, 0);
      iRst = 1'b0;
      @(negedge iClk);

      for (int v = 0; v < 5; v++) begin
         runWindow($sformatf("vec%0d", v), vec[v].a, vec[v].b, vec[v].gap, 1'b0, 1'b0,
                   vec[v].eSum, vec[v].eSq, vec[v].eCorr, vec[v].eMax, vec[v].eMin, vec[v].eOut);
         step(1'b0, 1'b0, 16'd0, 16'd0);
         chk($sformatf("vec%0d done one cycle", v), longint'(oDone), 0);
      end

      // valid pulses while idle must neither start nor disturb held results
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 16'd20000, 16'd20000);
         chk("idle valid busy", longint'(oBusy), 0);
         chk("idle valid done", longint'(oDone), 0);
      end
      step(1'b0, 1'b0, 16'd0, 16'd0);
      chk("held sumsq", longint'(oSumSq), 536870912);
      chk("held outliers", longint'(oOutliers), 0);

      runWindow("start+valid", vec[0].a, vec[0].b, 0, 1'b1, 1'b0,
                0, 33554432, -16777216, 2048, -2048, 0);
      runWindow("mid start", vec[0].a, vec[0].b, 1, 1'b0, 1'b1,
                0, 33554432, -16777216, 2048, -2048, 0);

      // back-to-back random windows: each start lands in the cycle done is high
      for (int w = 0; w < 25; w++) begin
         quadT a, b;
         longint s, q, c;
         int mx, mn, o;
         for (int i = 0; i < 4; i++) begin
            a[i] = rnd();
            b[i] = rnd();
         end
         model(a, b, s, q, c, mx, mn, o);
         runWindow($sformatf("rand%0d", w), a, b, int'($urandom_range(0, 2)), 1'b0, 1'b0,
                   s, q, c, mx, mn, o);
      end

      step(1'b0, 1'b0, 16'd0, 16'd0);
      step(1'b1, 1'b0, 16'd0, 16'd0);
      step(1'b0, 1'b1, 16'd2048, -16'sd2048);
      step(1'b0, 1'b1, 16'd2048, -16'sd2048);
      iValid = 1'b0;
      iRst = 1'b1;
      #1;
      chk("async reset busy", longint'(oBusy), 0);
      chk("async reset done", longint'(oDone), 0);
      chkRes("async reset", 0, 0, 0, 0, 0, 0);
      @(negedge iClk);
      iRst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 16'd0, 16'd0);
         chk("post reset no done", longint'(oDone), 0);
         chk("post reset idle", longint'(oBusy), 0);
      end
      runWindow("after reset", vec[0].a, vec[0].b, 0, 1'b0, 1'b0,
                0, 33554432, -16777216, 2048, -2048, 0);
      step(1'b0, 1'b0, 16'd0, 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
